// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, imem req/ack, decode valid/ready slot, redirect squash
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alvoDesvio,
  input  logic        desvioTomado,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        erroAlinhamento
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        misaligned;

  // A redirect to a non-word-aligned target halts the front end.
  assign misaligned = desvioTomado && (alvoDesvio[1:0] != 2'b00);

  // Next-state and registered-output computation for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    err_d      = err_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;

    if (state_q != S_ERR && misaligned) begin
      err_d   = 1'b1;
      req_d   = 1'b0;
      valid_d = 1'b0;
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!req_q) begin
            // First cycle out of reset: launch the initial request.
            req_d  = 1'b1;
            addr_d = desvioTomado ? alvoDesvio : pc_q;
          end else if (imem_ack) begin
            if (pend_q || desvioTomado) begin
              // Returned word belongs to a squashed path; refetch at the newest target.
              addr_d = desvioTomado ? alvoDesvio : pend_tgt_q;
              pend_d = 1'b0;
            end else begin
              inst_d    = imem_rdata;
              inst_pc_d = addr_q;
              valid_d   = 1'b1;
              pc_d      = addr_q + 32'd4;
              req_d     = 1'b0;
              state_d   = S_HOLD;
            end
          end else if (desvioTomado) begin
            // Request must stay stable until ack, so remember the redirect.
            pend_d     = 1'b1;
            pend_tgt_d = alvoDesvio;
          end
        end
        S_HOLD: begin
          if (desvioTomado) begin
            valid_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = alvoDesvio;
            state_d = S_REQ;
          end else if (valid_q && inst_ready) begin
            valid_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = S_REQ;
          end
        end
        S_ERR: begin
        end
        default: begin
          state_d = S_ERR;
          req_d   = 1'b0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  // State register; reset clears everything asynchronously, abandoning any request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      valid_q    <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign inst_valid      = valid_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;
  assign erroAlinhamento = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with program-order reference model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alvo = 32'h0;
  logic        desv = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        iv;
  logic [31:0] ins;
  logic [31:0] ipc;
  logic        ready = 1'b0;
  logic        err;

  logic        rst2 = 1'b1;
  logic [31:0] alvo2 = 32'h0;
  logic        desv2 = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        iv2;
  logic [31:0] ins2;
  logic [31:0] ipc2;
  logic        ready2 = 1'b0;
  logic        err2;

  int errors = 0;
  int checks = 0;
  int nxfer  = 0;

  logic [31:0] want_pc;
  logic        bpend;
  logic [31:0] bpt;
  logic [31:0] fetched[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock(clk), .reset(rst), .alvoDesvio(alvo), .desvioTomado(desv),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .inst_valid(iv), .inst(ins), .inst_pc(ipc), .inst_ready(ready),
    .erroAlinhamento(err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clk), .reset(rst2), .alvoDesvio(alvo2), .desvioTomado(desv2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .inst_valid(iv2), .inst(ins2), .inst_pc(ipc2), .inst_ready(ready2),
    .erroAlinhamento(err2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; ready = 1'b0; desv = 1'b0; alvo = 32'h0;
    tick(); tick();
    chk1("rst_req", req, 1'b0);
    chk ("rst_addr", addr, 32'h0);
    chk1("rst_valid", iv, 1'b0);
    chk ("rst_inst", ins, 32'h0);
    chk ("rst_inst_pc", ipc, 32'h0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    want_pc = 32'h0;
    bpend = 1'b0;
    bpt = 32'h0;
    fetched.delete();
  endtask

  // One cycle: apply inputs, update the program-order model, then check the outcome.
  task automatic drive(input logic a, input logic r, input logic d, input logic [31:0] t);
    logic o_req, o_iv, o_err, mis, e_req, e_iv, e_err, c_addr, c_slot;
    logic [31:0] o_addr, o_ipc, o_ins, e_addr, e_ipc, e_ins;
    o_req = req; o_iv = iv; o_err = err; o_addr = addr; o_ipc = ipc; o_ins = ins;
    ack = a; ready = r; desv = d; alvo = t; rdata = memw(o_addr);
    mis = d && (t[1:0] != 2'b00);
    e_err = o_err; e_req = 1'b0; e_iv = 1'b0; c_addr = 1'b0; c_slot = 1'b0;
    e_addr = o_addr; e_ipc = o_ipc; e_ins = o_ins;
    if (o_err || mis) begin
      e_err = 1'b1;
    end else begin
      if (o_iv && r && !d) begin
        chk("xfer_pc", o_ipc, want_pc);
        chk("xfer_inst", o_ins, memw(want_pc));
        want_pc = want_pc + 32'd4;
        nxfer++;
      end
      if (d) want_pc = t;
      if (o_req) begin
        if (!a) begin
          e_req = 1'b1; c_addr = 1'b1;
          if (d) begin bpend = 1'b1; bpt = t; end
        end else begin
          fetched.push_back(o_addr);
          if (d) begin
            e_req = 1'b1; c_addr = 1'b1; e_addr = t; bpend = 1'b0;
          end else if (bpend) begin
            e_req = 1'b1; c_addr = 1'b1; e_addr = bpt; bpend = 1'b0;
          end else begin
            e_iv = 1'b1; c_slot = 1'b1; e_ipc = o_addr; e_ins = memw(o_addr);
          end
        end
      end else if (o_iv) begin
        if (d || r) begin
          e_req = 1'b1; c_addr = 1'b1; e_addr = want_pc;
        end else begin
          e_iv = 1'b1; c_slot = 1'b1;
        end
      end else begin
        e_req = 1'b1; c_addr = 1'b1; e_addr = want_pc;
      end
    end
    tick();
    chk1("cyc_req", req, e_req);
    chk1("cyc_valid", iv, e_iv);
    chk1("cyc_err", err, e_err);
    if (c_addr) chk("cyc_addr", addr, e_addr);
    if (c_slot) begin
      chk("slot_pc", ipc, e_ipc);
      chk("slot_inst", ins, e_ins);
    end
  endtask

  task automatic reach_hold(input string tag);
    for (int i = 0; i < 20 && !iv; i++) drive(req, 1'b0, 1'b0, 32'h0);
    chk1(tag, iv, 1'b1);
  endtask

  initial begin
    logic [31:0] held_pc;
    logic        ra, rr, rd;
    logic [31:0] rt;

    // Wrap-around instance: RESET_PC = FFFF_FFFC, second fetch at 0.
    tick();
    rst2 = 1'b0;
    tick();
    chk1("wrap_req0", req2, 1'b1);
    chk ("wrap_addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; rdata2 = memw(addr2);
    tick();
    chk1("wrap_valid", iv2, 1'b1);
    chk ("wrap_inst_pc", ipc2, 32'hFFFF_FFFC);
    chk ("wrap_inst", ins2, memw(32'hFFFF_FFFC));
    ack2 = 1'b0; ready2 = 1'b1;
    tick();
    chk1("wrap_req1", req2, 1'b1);
    chk ("wrap_addr1", addr2, 32'h0);
    ready2 = 1'b0;
    #2 rst2 = 1'b1;
    #1;
    chk1("wrap_async_rst_req", req2, 1'b0);
    chk1("wrap_err", err2, 1'b0);

    // Zero-latency memory, decode always ready: 0,4,8,C in order.
    do_reset();
    for (int i = 0; i < 12; i++) drive(req, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      chk("seq_addr", (fetched.size() > i) ? fetched[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Decode stall for 5 cycles in HOLD, then release.
    reach_hold("stall_reach_hold");
    held_pc = ipc;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_next_addr", addr, held_pc + 32'd4);

    // Redirect while waiting on a slow ack: word from 0x10 is squashed.
    reach_hold("slow_reach_hold");
    drive(1'b0, 1'b0, 1'b1, 32'h10);
    chk("slow_req_addr", addr, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk1("slow_req_after_ack", req, 1'b1);
    chk ("slow_addr_after_ack", addr, 32'h80);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("slow_inst_pc", ipc, 32'h80);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect and ready together in HOLD: redirect wins.
    reach_hold("prio_reach_hold");
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    chk1("prio_valid", iv, 1'b0);
    chk ("prio_addr", addr, 32'h40);

    // Misaligned target: sticky halt until reset.
    drive(req, 1'b0, 1'b1, 32'h42);
    chk1("mis_err", err, 1'b1);
    chk1("mis_req", req, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ra = 1'($urandom & 1); rr = 1'($urandom & 1); rd = 1'($urandom & 1);
      drive(ra, rr, rd, $urandom);
    end
    do_reset();

    // Random traffic against the program-order model.
    for (int i = 0; i < 1500; i++) begin
      ra = req && ($urandom_range(2, 0) == 0);
      rr = ($urandom_range(1, 0) == 0);
      rd = ($urandom_range(9, 0) == 0);
      rt = {22'h0, 8'($urandom), 2'b00};
      drive(ra, rr, rd, rt);
    end
    chk1("rand_progress", nxfer > 100, 1'b1);

    // Asynchronous reset while a request is outstanding.
    for (int i = 0; i < 10 && !req; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("async_setup_req", req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_req", req, 1'b0);
    chk1("async_rst_valid", iv, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
